uop_dispatch: RTL

//  Consumer of the front-end microcode word. Buffers decoded uops in an in-order queue,

---
 rtl/Purple_Jade_pkg.sv | 58 +++++
 rtl/uop_scoreboard.sv | 41 ++++
 rtl/uop_dispatch.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/Purple_Jade_pkg.sv
// rtl/Purple_Jade_pkg.sv - microcode word layout, FU/OP codes and source-usage decode
// Shared by the dispatch queue, its scoreboard and any bench building microcode words.
package Purple_Jade_pkg;

    localparam int UCODE_WIDTH_P = 16;
    localparam int REG_IDX_W     = 4;

    typedef enum logic [2:0] {
        ALU_FU     = 3'd0,
        LOGICAL_FU = 3'd1,
        MUL_FU     = 3'd2,
        DIV_FU     = 3'd3,
        MEM_FU     = 3'd4,
        BRANCH_FU  = 3'd5,
        NOOP_FU    = 3'd7
    } fu_e;

    typedef enum logic [3:0] {
        ADD_OP = 4'd0,
        SUB_OP = 4'd1,
        AND_OP = 4'd2,
        ORR_OP = 4'd3,
        MUL_OP = 4'd4,
        DIV_OP = 4'd5,
        LDR_OP = 4'd6,
        STR_OP = 4'd7,
        CMP_OP = 4'd8,
        B_OP   = 4'd9,
        BCC_OP = 4'd10,
        NOP_OP = 4'd11
    } op_e;

    // Field order matches the ROM word {WE,OP,FU,FLAGS,DST,S1,S2,IMM}, MSB first.
    typedef struct packed {
        logic       we;
        logic [3:0] op;
        logic [2:0] fu;
        logic [3:0] flags;
        logic       dst;
        logic       s1;
        logic       s2;
        logic       imm;
    } ucode_s;

    function automatic logic uses_rs1(input logic s1);
        return s1;
    endfunction

    // An immediate replaces the second register operand.
    function automatic logic uses_rs2(input logic s2, input logic imm);
        return s2 & ~imm;
    endfunction

    function automatic logic uses_flags(input logic [3:0] op);
        return op == BCC_OP;
    endfunction

endpackage

// File: rtl/uop_scoreboard.sv
// rtl/uop_scoreboard.sv - register busy vector plus flags-busy bit
// A set and a clear of the same bit in one cycle leaves the bit set.
module uop_scoreboard
    import Purple_Jade_pkg::*;
#(
    parameter int NUM_REGS_P = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  set_v_i,
    input  logic [REG_IDX_W-1:0]  set_idx_i,
    input  logic                  clr_v_i,
    input  logic [REG_IDX_W-1:0]  clr_idx_i,
    input  logic                  flags_set_i,
    input  logic                  flags_clr_i,
    output logic [NUM_REGS_P-1:0] busy_o,
    output logic                  flags_busy_o
);

    logic [NUM_REGS_P-1:0] r_busy;
    logic                  r_flags_busy;
    logic [NUM_REGS_P-1:0] w_set_mask;
    logic [NUM_REGS_P-1:0] w_clr_mask;

    assign w_set_mask = {{(NUM_REGS_P-1){1'b0}}, set_v_i} << set_idx_i;
    assign w_clr_mask = {{(NUM_REGS_P-1){1'b0}}, clr_v_i} << clr_idx_i;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_busy       <= '0;
            r_flags_busy <= 1'b0;
        end else begin
            r_busy       <= (r_busy & ~w_clr_mask) | w_set_mask;
            r_flags_busy <= (r_flags_busy & ~flags_clr_i) | flags_set_i;
        end
    end

    assign busy_o       = r_busy;
    assign flags_busy_o = r_flags_busy;

endmodule

// File: rtl/uop_dispatch.sv
// rtl/uop_dispatch.sv - in-order uop queue with hazard check and one-hot FU issue
// Head uop issues when its sources, flags and destination are free; NOOP/invalid FU drains.
module uop_dispatch
    import Purple_Jade_pkg::*;
#(
    parameter int DEPTH_P    = 4,
    parameter int NUM_REGS_P = 16,
    parameter int NUM_FU_P   = 6
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     flush_i,
    input  logic                     uop_v_i,
    output logic                     uop_ready_o,
    input  logic [UCODE_WIDTH_P-1:0] ucode_i,
    input  logic [3:0]               rd_i,
    input  logic [3:0]               rs1_i,
    input  logic [3:0]               rs2_i,
    input  logic [31:0]              imm_i,
    input  logic [31:0]              pc_i,
    output logic [NUM_FU_P-1:0]      issue_v_o,
    input  logic [NUM_FU_P-1:0]      fu_ready_i,
    output logic [UCODE_WIDTH_P-1:0] issue_ucode_o,
    output logic [3:0]               issue_rd_o,
    output logic [3:0]               issue_rs1_o,
    output logic [3:0]               issue_rs2_o,
    output logic [31:0]              issue_imm_o,
    output logic [31:0]              issue_pc_o,
    input  logic                     wb_v_i,
    input  logic [3:0]               wb_rd_i,
    input  logic                     flags_wb_v_i,
    output logic [$clog2(DEPTH_P):0] count_o
);

    localparam int             PTR_W   = $clog2(DEPTH_P);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH_P);

    logic [UCODE_WIDTH_P-1:0] r_ucode [DEPTH_P];
    logic [3:0]               r_rd    [DEPTH_P];
    logic [3:0]               r_rs1   [DEPTH_P];
    logic [3:0]               r_rs2   [DEPTH_P];
    logic [31:0]              r_imm   [DEPTH_P];
    logic [31:0]              r_pc    [DEPTH_P];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [PTR_W:0]           r_count;

    ucode_s                   w_head;
    logic                     w_head_v;
    logic                     w_is_noop;
    logic [NUM_FU_P-1:0]      w_fu_onehot;
    logic [NUM_REGS_P-1:0]    w_sb_busy;
    logic                     w_sb_flags_busy;
    logic [NUM_REGS_P-1:0]    w_wb_mask;
    logic [NUM_REGS_P-1:0]    w_busy_eff;
    logic                     w_rs1_busy;
    logic                     w_rs2_busy;
    logic                     w_rd_busy;
    logic                     w_flags_busy_eff;
    logic                     w_hazard;
    logic                     w_can_issue;
    logic                     w_pop;
    logic                     w_issue_fire;
    logic                     w_enq;

    assign w_head   = ucode_s'(r_ucode[r_rd_ptr]);
    assign w_head_v = (r_count != '0);
    assign w_is_noop = (int'(w_head.fu) >= NUM_FU_P);
    assign w_fu_onehot = {{(NUM_FU_P-1){1'b0}}, ~w_is_noop} << w_head.fu;

    // A writeback landing this cycle releases its register for the head already.
    assign w_wb_mask  = {{(NUM_REGS_P-1){1'b0}}, wb_v_i} << wb_rd_i;
    assign w_busy_eff = w_sb_busy & ~w_wb_mask;
    assign w_rs1_busy = |(w_busy_eff & ({{(NUM_REGS_P-1){1'b0}}, 1'b1} << r_rs1[r_rd_ptr]));
    assign w_rs2_busy = |(w_busy_eff & ({{(NUM_REGS_P-1){1'b0}}, 1'b1} << r_rs2[r_rd_ptr]));
    assign w_rd_busy  = |(w_busy_eff & ({{(NUM_REGS_P-1){1'b0}}, 1'b1} << r_rd[r_rd_ptr]));
    assign w_flags_busy_eff = w_sb_flags_busy & ~flags_wb_v_i;

    assign w_hazard = (uses_rs1(w_head.s1) & w_rs1_busy)
                    | (uses_rs2(w_head.s2, w_head.imm) & w_rs2_busy)
                    | (uses_flags(w_head.op) & w_flags_busy_eff)
                    | (w_head.we & w_rd_busy);

    assign w_can_issue  = w_head_v & ~w_is_noop & ~w_hazard & ~flush_i;
    assign w_issue_fire = w_can_issue & |(fu_ready_i & w_fu_onehot);
    assign w_pop        = w_issue_fire | (w_head_v & w_is_noop & ~flush_i);

    assign uop_ready_o = ~reset_i & (r_count < DEPTH_C) & ~flush_i;
    assign w_enq       = uop_v_i & uop_ready_o;

    assign issue_v_o     = w_can_issue ? w_fu_onehot : '0;
    assign issue_ucode_o = r_ucode[r_rd_ptr];
    assign issue_rd_o    = r_rd[r_rd_ptr];
    assign issue_rs1_o   = r_rs1[r_rd_ptr];
    assign issue_rs2_o   = r_rs2[r_rd_ptr];
    assign issue_imm_o   = r_imm[r_rd_ptr];
    assign issue_pc_o    = r_pc[r_rd_ptr];
    assign count_o       = r_count;

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_ucode[r_wr_ptr] <= ucode_i;
            r_rd[r_wr_ptr]    <= rd_i;
            r_rs1[r_wr_ptr]   <= rs1_i;
            r_rs2[r_wr_ptr]   <= rs2_i;
            r_imm[r_wr_ptr]   <= imm_i;
            r_pc[r_wr_ptr]    <= pc_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    uop_scoreboard #(
        .NUM_REGS_P(NUM_REGS_P)
    ) u_scoreboard (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .set_v_i     (w_issue_fire & w_head.we),
        .set_idx_i   (r_rd[r_rd_ptr]),
        .clr_v_i     (wb_v_i),
        .clr_idx_i   (wb_rd_i),
        .flags_set_i (w_issue_fire & (w_head.flags != 4'b0)),
        .flags_clr_i (flags_wb_v_i),
        .busy_o      (w_sb_busy),
        .flags_busy_o(w_sb_flags_busy)
    );

endmodule
